// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
//  Pipeline flow controller for a 5-stage CPU (IF/ID/EX/MEM/WB).
//  Produces the PC enable plus the enable and flush strobes for each pipeline
//  register. It tracks which stages hold real instructions, stalls on load-use
//  hazards, redirects on taken branches/jumps resolved in EX or MEM, and holds
//  the pipeline while a data-memory access is in its wait states.
//
//  Parameters
//   REG_ADDR_W    register-file address width
//   BRANCH_STAGE  2 = branch resolved in EX, 3 = branch resolved in MEM
//   MEM_WAIT      extra wait cycles per data-memory access (0..15)
//   CNT_W         performance counter width
//
//  Ports
//   clk, arst_n                  clock, asynchronous active-low reset
//   enable                       global run; 0 freezes all state and strobes
//   id_rs, id_rt, id_uses_rt     source registers of the instruction in ID
//   ex_mem_read, ex_rd           load flag and destination of the EX instruction
//   br_taken                     taken branch/jump from the BRANCH_STAGE registers
//   mem_req                      MEM instruction accesses data memory
//   pc_en                        PC update
//   en_*/flush_*                 pipeline register enables and bubble loads
//   valid_ex/mem/wb              stage holds a real instruction
//   stall_cnt/flush_cnt/retire_cnt  performance counters
//
//  Build option
//   HAZ_PERF_CNT_EN  when defined, the performance counters are built;
//                    otherwise the counter outputs are tied to 0.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit #(
   parameter int REG_ADDR_W   = 5,
   parameter int BRANCH_STAGE = 3,
   parameter int MEM_WAIT     = 0,
   parameter int CNT_W        = 32
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  enable,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rt,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  br_taken,
   input  logic                  mem_req,
   output logic                  pc_en,
   output logic                  en_if_id,
   output logic                  en_id_ex,
   output logic                  en_ex_mem,
   output logic                  en_mem_wb,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  flush_ex_mem,
   output logic                  flush_mem_wb,
   output logic                  valid_ex,
   output logic                  valid_mem,
   output logic                  valid_wb,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      retire_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic v_id;
   logic busy;
   logic lu;
   logic redir;
   logic br_valid;

   generate
      if (BRANCH_STAGE != 2 && BRANCH_STAGE != 3) begin : g_bad_stage
         $error("hazard_ctrl_unit: BRANCH_STAGE must be 2 (EX) or 3 (MEM)");
      end
      if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_bad_wait
         $error("hazard_ctrl_unit: MEM_WAIT must be in 0..15");
      end
   endgenerate

   // The branch qualifier is the valid bit of the stage holding the resolved branch.
   assign br_valid = (BRANCH_STAGE == 2) ? valid_ex : valid_mem;

   assign lu = valid_ex & ex_mem_read & (ex_rd != '0) & v_id &
               ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

   assign redir = br_taken & br_valid;

   // Memory wait-state tracker. busy rises in the same cycle the access is seen
   // in MEM and stays high for MEM_WAIT cycles in total; the access leaves MEM
   // in the cycle after the last busy cycle.
   generate
      if (MEM_WAIT > 0) begin : g_wait
         localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);
         logic [0:0] state;
         logic [3:0] wait_cnt;

         always_comb begin
            busy = 1'b0;
            if (state == ST_WAIT) busy = (wait_cnt != 4'd0);
            else                  busy = mem_req & valid_mem;
         end

         always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
               state    <= ST_IDLE;
               wait_cnt <= 4'd0;
            end else if (enable) begin
               if (state == ST_IDLE) begin
                  if (mem_req & valid_mem) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end
               end else begin
                  if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                  else                  state    <= ST_IDLE;
               end
            end
         end
      end else begin : g_no_wait
         logic unused_mem_req;
         assign unused_mem_req = mem_req;
         assign busy = 1'b0;
      end
   endgenerate

   // Strobe generation, highest priority first: freeze, memory busy,
   // redirect, load-use stall, free run. Everything is low during reset.
   always_comb begin
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      en_ex_mem    = 1'b0;
      en_mem_wb    = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      flush_mem_wb = 1'b0;
      if (arst_n && enable) begin
         if (busy) begin
            // Hold IF..MEM; push a bubble into WB so nothing retires twice.
            en_mem_wb    = 1'b1;
            flush_mem_wb = 1'b1;
         end else if (redir) begin
            pc_en        = 1'b1;
            en_if_id     = 1'b1;
            en_id_ex     = 1'b1;
            en_ex_mem    = 1'b1;
            en_mem_wb    = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = (BRANCH_STAGE == 3);
         end else if (lu) begin
            en_id_ex     = 1'b1;
            flush_id_ex  = 1'b1;
            en_ex_mem    = 1'b1;
            en_mem_wb    = 1'b1;
         end else begin
            pc_en        = 1'b1;
            en_if_id     = 1'b1;
            en_id_ex     = 1'b1;
            en_ex_mem    = 1'b1;
            en_mem_wb    = 1'b1;
         end
      end
   end

   // Valid bits follow the instruction they describe; a flush loads a bubble.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         v_id      <= 1'b0;
         valid_ex  <= 1'b0;
         valid_mem <= 1'b0;
         valid_wb  <= 1'b0;
      end else begin
         if (en_if_id)  v_id      <= ~flush_if_id;
         if (en_id_ex)  valid_ex  <= flush_id_ex  ? 1'b0 : v_id;
         if (en_ex_mem) valid_mem <= flush_ex_mem ? 1'b0 : valid_ex;
         if (en_mem_wb) valid_wb  <= flush_mem_wb ? 1'b0 : valid_mem;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Stall and flush counts reflect the action actually taken: a load-use
   // hazard masked by a redirect is not a stall, and a redirect held off by
   // a busy memory counts once, when it finally takes effect.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         retire_cnt <= '0;
      end else if (enable) begin
         stall_cnt  <= stall_cnt  + CNT_W'(busy | (lu & ~redir));
         flush_cnt  <= flush_cnt  + CNT_W'(redir & ~busy);
         retire_cnt <= retire_cnt + CNT_W'(valid_wb);
      end
   end
`else
   assign stall_cnt  = '0;
   assign flush_cnt  = '0;
   assign retire_cnt = '0;
`endif

endmodule
